// File: rtl/fwrisc_wb_arb_pkg.sv
// Shared types and constants for the fwrisc Wishbone arbiter.
package fwrisc_wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/fwrisc_rr_pick.sv
// Combinational rotating priority picker: first set request at or after start_i, wrapping.
module fwrisc_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        // Walk from the farthest candidate back to start_i so the nearest request wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(start_i) + k) % N]) begin
                idx_o = W'((int'(start_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fwrisc_wb_arbiter.sv
// N-to-1 Wishbone arbiter with fixed or round-robin priority and a per-transaction watchdog.
module fwrisc_wb_arbiter
    import fwrisc_wb_arb_pkg::*;
#(
    parameter int N_INITIATORS = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ARB_MODE     = 1,
    parameter int TIMEOUT      = 0,
    localparam int GW          = (N_INITIATORS > 1) ? $clog2(N_INITIATORS) : 1,
    localparam int SW          = DATA_WIDTH / 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_INITIATORS*ADDR_WIDTH-1:0] i_adr,
    input  logic [N_INITIATORS*DATA_WIDTH-1:0] i_dat_w,
    output logic [N_INITIATORS*DATA_WIDTH-1:0] i_dat_r,
    input  logic [N_INITIATORS*SW-1:0]         i_sel,
    input  logic [N_INITIATORS-1:0]            i_cyc,
    input  logic [N_INITIATORS-1:0]            i_stb,
    input  logic [N_INITIATORS-1:0]            i_we,
    output logic [N_INITIATORS-1:0]            i_ack,
    output logic [N_INITIATORS-1:0]            i_err,
    output logic [ADDR_WIDTH-1:0]              t_adr,
    output logic [DATA_WIDTH-1:0]              t_dat_w,
    output logic [SW-1:0]                      t_sel,
    output logic                               t_cyc,
    output logic                               t_stb,
    output logic                               t_we,
    input  logic [DATA_WIDTH-1:0]              t_dat_r,
    input  logic                               t_ack,
    input  logic                               t_err,
    output logic [GW-1:0]                      grant,
    output logic                               busy
);

    localparam int N       = N_INITIATORS;
    localparam int WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    arb_state_e     state_q;
    logic [GW-1:0]  grant_q;
    logic [GW-1:0]  last_grant_q;
    logic [WDW-1:0] wd_q;

    logic [N-1:0]   req;
    logic [GW-1:0]  start;
    logic [GW-1:0]  pick_idx;
    logic           pick_valid;
    logic           in_busy;
    logic           cyc_g;
    logic           stb_g;
    logic           done;
    logic           abort;
    logic           wd_fire;

    assign req     = i_cyc & i_stb;
    assign in_busy = (state_q == BUSY);
    assign cyc_g   = i_cyc[grant_q];
    assign stb_g   = i_stb[grant_q];
    assign done    = t_ack | t_err;
    assign abort   = ~cyc_g;
    assign wd_fire = (TIMEOUT > 0) && (wd_q == WDW'(WD_LAST)) && !done;

    always_comb begin
        start = '0;
        if (ARB_MODE == ARB_RR) begin
            start = (last_grant_q == GW'(N - 1)) ? '0 : last_grant_q + 1'b1;
        end
    end

    fwrisc_rr_pick #(
        .N (N),
        .W (GW)
    ) u_pick (
        .req_i   (req),
        .start_i (start),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        t_adr   = '0;
        t_dat_w = '0;
        t_sel   = '0;
        t_cyc   = 1'b0;
        t_stb   = 1'b0;
        t_we    = 1'b0;
        i_dat_r = '0;
        i_ack   = '0;
        i_err   = '0;
        if (in_busy) begin
            t_adr   = i_adr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
            t_dat_w = i_dat_w[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            t_sel   = i_sel[int'(grant_q)*SW +: SW];
            t_we    = i_we[grant_q];
            t_cyc   = cyc_g & ~wd_fire;
            t_stb   = cyc_g & stb_g & ~wd_fire;
            i_dat_r[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = t_dat_r;
            // An abort suppresses any response; ack together with err counts as err.
            i_ack[grant_q] = cyc_g & t_ack & ~t_err;
            i_err[grant_q] = cyc_g & (t_err | wd_fire);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N - 1);
            wd_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (pick_valid) begin
                        grant_q      <= pick_idx;
                        last_grant_q <= pick_idx;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (abort || done || wd_fire) begin
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = in_busy;

endmodule

// File: doc/fwrisc_wb_arbiter.md
# fwrisc_wb_arbiter

Parametrised Wishbone arbiter that merges N initiator ports (e.g. the core's instruction and data ports, plus debug/DMA) onto one Wishbone target port. It sits between `fwrisc_wb`-class cores and a single-ported memory/peripheral fabric. It supports fixed-priority or round-robin arbitration. A per-transaction timeout watchdog returns `err` to the requester if the target never responds.

## Interface
Parameters:
- `N_INITIATORS`, 2: number of initiator ports (1..8).
- `ADDR_WIDTH`, 32: Wishbone address width.
- `DATA_WIDTH`, 32: Wishbone data width. Must be a multiple of 8.
- `ARB_MODE`, 1: 0 = fixed priority (index 0 highest); 1 = round-robin.
- `TIMEOUT`, 0: cycles in BUSY before forced error. 0 disables the watchdog.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
  - `clock` in 1: sole clock. All state updates on rising edge.
  - `reset` in 1: synchronous, active-high.
- Initiator-side ports (packed, index i occupies slice i):
  - `i_adr` in N*ADDR_WIDTH: initiator addresses.
  - `i_dat_w` in N*DATA_WIDTH: initiator write data.
  - `i_dat_r` out N*DATA_WIDTH: read data returned to initiators.
  - `i_sel` in N*(DATA_WIDTH/8): byte selects.
  - `i_cyc`, `i_stb`, `i_we` in N: cycle, strobe and write-enable per initiator.
  - `i_ack`, `i_err` out N: per-initiator ack and err.
- Target-side port:
  - `t_adr` out ADDR_WIDTH, `t_dat_w` out DATA_WIDTH, `t_sel` out DATA_WIDTH/8.
  - `t_cyc`, `t_stb`, `t_we` out 1.
  - `t_dat_r` in DATA_WIDTH, `t_ack` in 1, `t_err` in 1.
- Status:
  - `grant` out $clog2(N) (min 1): index of current owner. Valid while `busy`.
  - `busy` out 1: a transaction is in flight.

## Operation
- State machine: IDLE, BUSY.
- Request vector: `req[i] = i_cyc[i] & i_stb[i]`.
- IDLE:
  - If `req` is non-zero, pick a winner and register it in `grant`, then go to BUSY.
  - Fixed mode: the lowest index wins.
  - Round-robin mode: search starts at `(last_grant+1) mod N` and wraps. `last_grant` updates to the winner.
- BUSY, outputs:
  - `t_*` are driven combinationally from the slice `grant` of the initiator inputs.
  - `i_dat_r[grant] = t_dat_r`, `i_ack[grant] = t_ack`, `i_err[grant] = t_err`.
  - All other `i_ack`/`i_err` are 0. Non-granted `i_dat_r` slices are 0.
- BUSY, exits (all return to IDLE next cycle):
  - Target `t_ack` or `t_err`: complete.
  - Initiator drops `i_cyc[grant]` (abort): `t_cyc` deasserts the same cycle, and no ack/err is returned.
  - Watchdog, when `TIMEOUT>0`: counter `wd` clears on entry to BUSY and increments each BUSY cycle with no ack/err. When `wd == TIMEOUT-1` and no ack/err, drive `i_err[grant]=1` for that cycle and force `t_cyc=t_stb=0`.
- Precedence on simultaneous events: `t_ack`/`t_err` over watchdog; initiator abort over everything. `t_ack` and `t_err` together are treated as err.
- Requests arriving during BUSY wait; an initiator's request is held by its own `cyc`/`stb`.
- IDLE outputs: all `t_*`, `i_ack`, `i_err` and `i_dat_r` are 0.

## Timing
- Reset values:
  - State IDLE; `busy=0`, `grant=0`.
  - `last_grant=N-1`, so initiator 0 is first in round-robin.
  - `wd=0`, all outputs 0.
- Grant latency: a request sampled in cycle c gives `t_cyc`/`t_stb` high in cycle c+1.
- Completion: an ack in cycle k is passed combinationally in cycle k. The arbiter is in IDLE in cycle k+1.
- Throughput: one dead cycle between transactions, so the maximum is 1 transfer per 2 cycles plus target wait states.
- Reset mid-transaction: the next cycle is IDLE with all outputs 0. No ack/err is returned to the aborted initiator.
- `N_INITIATORS=1`: the arbiter degenerates to a registered-grant passthrough with the same latency.

## Structure
- Package `fwrisc_wb_arb_pkg`:
  - `arb_state_e {IDLE, BUSY}`.
  - Constants `ARB_FIXED=0`, `ARB_RR=1`.
- Sub-module `fwrisc_rr_pick`: combinational priority picker.
  - Inputs: N-bit request and start index. Outputs: winner index and valid.
  - Fixed mode uses start = 0.
- The top level contains the FSM, grant and `last_grant` registers, the watchdog and the muxes.

## Test plan
- Single read, N=2, RR: init 0 reads `0x1000`; target acks after 3 wait states with `0xDEADBEEF`.
  - `t_cyc` rises 1 cycle after the request.
  - `i_dat_r[0]=0xDEADBEEF` with `i_ack[0]` for one cycle; `i_ack[1]` stays 0.
- Contention, RR: both initiators request continuously; target acks immediately. Grants must go 0,1,0,1.
- Contention, fixed (`ARB_MODE=0`), same stimulus: initiator 0 wins every arbitration while it requests.
- Timeout, `TIMEOUT=8`: target never acks.
  - `i_err[grant]` pulses in the 8th BUSY cycle and `t_cyc` drops.
  - `busy=0` the next cycle.
- Ack/timeout collision, `TIMEOUT=4`: target acks exactly in the 4th BUSY cycle. Only `i_ack` asserts; no `i_err`.
- Abort and reset: initiator drops `cyc` mid-wait, then `t_cyc=0` the same cycle and no ack. Separately, reset asserted during BUSY gives all outputs 0 and `grant=0` the next cycle.
